// File: rtl/proc_out_fifo.sv
// proc_out_fifo: output-port buffer behind the processor I/O output bus.
// Captures out_en writes addressed to PORT into a circular buffer and drains
// them through a show-ahead valid/ready stream. Reports fill level, full and
// a sticky overflow flag.
// Optional feature macro: OUT_FIFO_ITR_EN. When defined, itr pulses for one
// cycle when a pop takes count from ITRLVL+1 down to ITRLVL. When undefined,
// itr is tied low and ITRLVL is ignored.
module proc_out_fifo #(
  parameter int NUBITS = 16,
  parameter int NBIOOU = 2,
  parameter int PORT   = 0,
  parameter int FDEPTH = 8,
  parameter int ITRLVL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUBITS-1:0]         io_out,
  input  logic [NBIOOU-1:0]         addr_out,
  input  logic                      out_en,
  output logic [NUBITS-1:0]         m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(FDEPTH):0]   count,
  output logic                      full,
  output logic                      ovf,
  input  logic                      ovf_clr,
  output logic                      itr
);

  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;

  // The refill threshold only matters in the interrupt build; it must stay
  // below the depth or the interrupt could never fire.
  generate
    if (ITRLVL >= FDEPTH) begin : g_itrlvl_out_of_range
    end
  endgenerate

  logic [NUBITS-1:0] mem [FDEPTH];

  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next, count_rem;
  logic              valid_reg, valid_next;
  logic              full_reg, full_next;
  logic              ovf_reg, ovf_next;
  logic              byp_sel_reg;
  logic [NUBITS-1:0] byp_data_reg;
  logic [NUBITS-1:0] ram_q_reg;

  logic              wr, rd, wr_acc, ovf_set, byp_now;

  // Handshake decode, pointer/count arithmetic and overflow handling.
  always_comb begin
    wr          = out_en && (addr_out == NBIOOU'(PORT));
    rd          = valid_reg && m_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    wr_acc      = wr && (!full_reg || rd);
    ovf_set     = wr && full_reg && !rd;
    rd_ptr_next = rd     ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    wr_ptr_next = wr_acc ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    count_rem   = count_reg - CW'(rd);
    count_next  = count_rem + CW'(wr_acc);
    valid_next  = (count_next != '0);
    full_next   = (count_next == CW'(FDEPTH));
    // The new word becomes the head when nothing older remains after the pop;
    // the RAM read below cannot see it yet, so it is captured on the side.
    byp_now     = wr_acc && (count_rem == '0);
    ovf_next    = ovf_reg;
    if (ovf_clr) ovf_next = 1'b0;
    if (ovf_set) ovf_next = 1'b1;
  end

  // Control state: pointers, fill level, flags and head-source select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      valid_reg   <= 1'b0;
      full_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      byp_sel_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      valid_reg   <= valid_next;
      full_reg    <= full_next;
      ovf_reg     <= ovf_next;
      byp_sel_reg <= byp_now;
    end
  end

  // Buffer storage with registered read of the next head (read-first).
  // While stalled the read address is unchanged, so the head word holds.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= io_out;
    ram_q_reg <= mem[rd_ptr_next];
  end

  // Side copy of a word written straight into the head slot; the RAM output
  // catches up one edge later, when byp_sel_reg drops back to 0.
  always_ff @(posedge clk) begin
    if (byp_now) byp_data_reg <= io_out;
  end

  // Head word is forced to 0 while invalid so reset shows 0 immediately.
  always_comb begin
    m_data = '0;
    if (valid_reg) m_data = byp_sel_reg ? byp_data_reg : ram_q_reg;
  end

  assign m_valid = valid_reg;
  assign count   = count_reg;
  assign full    = full_reg;
  assign ovf     = ovf_reg;

`ifdef OUT_FIFO_ITR_EN
  logic itr_reg, itr_next;

  // Refill request: only a pure pop crossing down onto the threshold fires.
  always_comb begin
    itr_next = rd && !wr_acc && (count_reg == CW'(ITRLVL + 1));
  end

  // One-cycle registered interrupt pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) itr_reg <= 1'b0;
    else      itr_reg <= itr_next;
  end

  assign itr = itr_reg;
`else
  assign itr = 1'b0;
`endif

endmodule

// File: tb/tb_proc_out_fifo.sv
// Directed self-checking bench for proc_out_fifo (FDEPTH=8, PORT=0, ITRLVL=2).
module tb_proc_out_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] io_out = '0;
  logic [1:0]  addr_out = '0;
  logic        out_en = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  count;
  logic        full;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic        itr;

  int errors = 0;
  int checks = 0;

`ifdef OUT_FIFO_ITR_EN
  localparam bit ITR_ON = 1'b1;
`else
  localparam bit ITR_ON = 1'b0;
`endif

  proc_out_fifo #(
    .NUBITS(16), .NBIOOU(2), .PORT(0), .FDEPTH(8), .ITRLVL(2)
  ) dut (
    .clk(clk), .rst(rst), .io_out(io_out), .addr_out(addr_out),
    .out_en(out_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .full(full), .ovf(ovf), .ovf_clr(ovf_clr), .itr(itr)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL reset_itr: got %b expected 0", itr); end
    checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", m_data); end
    $display("reset: count=%0d valid=%b data=%h", count, m_valid, m_data);
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    m_ready = 1'b0;
    addr_out = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      io_out = 16'h1111 * 16'(i);
      out_en = 1'b1;
      step();
      $display("write: data=%h count=%0d", io_out, count);
      if (i == 1) begin
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL wr_latency: valid got %b expected 1", m_valid); end
      end
    end
    out_en = 1'b0;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== 16'h1111) begin errors++; $display("FAIL basic_head: got %h expected 1111", m_data); end
    m_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h1111 * 16'(i)) begin
        errors++; $display("FAIL basic_drain: got valid=%b data=%h expected valid=1 data=%h", m_valid, m_data, 16'h1111 * 16'(i));
      end
      $display("read: data=%h", m_data);
      step();
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_valid: got %b expected 0", m_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_empty_count: got %0d expected 0", count); end
  endtask

  task automatic test_other_port();
    addr_out = 2'd1;
    io_out = 16'hAAAA;
    out_en = 1'b1;
    step();
    out_en = 1'b0;
    addr_out = 2'd0;
    step();
    $display("write other port: data=AAAA count=%0d valid=%b", count, m_valid);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL other_port_count: got %0d expected 0", count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL other_port_valid: got %b expected 0", m_valid); end
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      io_out = 16'(i);
      out_en = 1'b1;
      step();
      $display("write: data=%h count=%0d full=%b ovf=%b", io_out, count, full, ovf);
      if (i == 8) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_at8: got %b expected 1", full); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf); end
      end
    end
    out_en = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'(i)) begin
        errors++; $display("FAIL ovf_drain: got valid=%b data=%h expected valid=1 data=%h", m_valid, m_data, 16'(i));
      end
      $display("read: data=%h", m_data);
      step();
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_end: valid got %b expected 0", m_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_clear: got %b expected 0", full); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    $display("ovf_clr: ovf=%b", ovf);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
  endtask

  task automatic test_full_pop();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      io_out = 16'h0010 + 16'(i);
      out_en = 1'b1;
      step();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullpop_full: got %b expected 1", full); end
    checks++; if (m_data !== 16'h0010) begin errors++; $display("FAIL fullpop_head: got %h expected 0010", m_data); end
    io_out = 16'h00FF;
    m_ready = 1'b1;
    step();
    out_en = 1'b0;
    m_ready = 1'b0;
    $display("write+pop while full: data=00FF count=%0d ovf=%b", count, ovf);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b expected 0", ovf); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fullpop_count: got %0d expected 8", count); end
    checks++; if (m_data !== 16'h0011) begin errors++; $display("FAIL fullpop_next: got %h expected 0011", m_data); end
    // Overflowing write and clear on the same edge: set wins.
    io_out = 16'hBEEF;
    out_en = 1'b1;
    ovf_clr = 1'b1;
    step();
    out_en = 1'b0;
    $display("overflow+clr: ovf=%b count=%0d", ovf, count);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", ovf); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL set_wins_count: got %0d expected 8", count); end
    step();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_after_set: got %b expected 0", ovf); end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp_w;
      exp_w = (i < 7) ? 16'h0011 + 16'(i) : 16'h00FF;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_w) begin
        errors++; $display("FAIL fullpop_drain: got valid=%b data=%h expected valid=1 data=%h", m_valid, m_data, exp_w);
      end
      $display("read: data=%h", m_data);
      step();
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fullpop_end: valid got %b expected 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    io_out = 16'h5001;
    out_en = 1'b1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_pre_valid: got %b expected 0", m_valid); end
    step();
    $display("write into empty: data=5001 valid=%b head=%h", m_valid, m_data);
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h5001) begin
      errors++; $display("FAIL b2b_no_bypass: got valid=%b data=%h expected valid=1 data=5001", m_valid, m_data);
    end
    for (int i = 2; i <= 3; i++) begin
      io_out = 16'h5000 + 16'(i);
      step();
      $display("write+pop at count 1: data=%h head=%h count=%0d", io_out, m_data, count);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h5000 + 16'(i) || count !== 4'd1) begin
        errors++; $display("FAIL b2b_replace: got valid=%b data=%h count=%0d expected valid=1 data=%h count=1", m_valid, m_data, count, 16'h5000 + 16'(i));
      end
    end
    out_en = 1'b0;
    step();
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL b2b_end: got valid=%b count=%0d expected valid=0 count=0", m_valid, count);
    end
  endtask

  task automatic test_stream();
    int wr_idx = 0;
    int rd_idx = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    while (rd_idx < 100 && cyc < 3000) begin
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++; $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", m_valid, m_data, prev_data);
        end
      end
      m_ready = ($urandom_range(0, 2) != 0);
      if (m_valid === 1'b1 && m_ready) begin
        checks++;
        if (m_data !== 16'h0100 + 16'(rd_idx)) begin
          errors++; $display("FAIL stream_order: got %h expected %h", m_data, 16'h0100 + 16'(rd_idx));
        end
        $display("stream read: data=%h", m_data);
        rd_idx++;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data = m_data;
      if (full === 1'b0 && wr_idx < 100 && $urandom_range(0, 3) != 0) begin
        io_out = 16'h0100 + 16'(wr_idx);
        out_en = 1'b1;
        wr_idx++;
      end else begin
        out_en = 1'b0;
      end
      step();
      cyc++;
    end
    out_en = 1'b0;
    m_ready = 1'b0;
    checks++; if (rd_idx != 100) begin errors++; $display("FAIL stream_total: got %0d words expected 100", rd_idx); end
    checks++; if (count !== 4'd0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL stream_empty: got count=%0d valid=%b expected count=0 valid=0", count, m_valid);
    end
  endtask

  task automatic test_itr_reset();
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      io_out = 16'h0200 + 16'(k);
      out_en = 1'b1;
      step();
      checks++; if (itr !== 1'b0) begin errors++; $display("FAIL itr_on_write: got %b expected 0", itr); end
    end
    out_en = 1'b0;
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      logic exp_itr;
      exp_itr = ITR_ON && (k == 3);
      step();
      $display("pop: count=%0d itr=%b", count, itr);
      checks++; if (itr !== exp_itr) begin errors++; $display("FAIL itr_pulse: pop %0d got %b expected %b", k, itr, exp_itr); end
      checks++; if (count !== 4'(5 - k)) begin errors++; $display("FAIL itr_count: got %0d expected %0d", count, 5 - k); end
    end
    m_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      io_out = 16'h0300 + 16'(j);
      out_en = 1'b1;
      step();
    end
    out_en = 1'b0;
    checks++; if (ovf !== 1'b1 || full !== 1'b1) begin
      errors++; $display("FAIL prereset_state: got ovf=%b full=%b expected 1 1", ovf, full);
    end
    #2;
    rst = 1'b0;
    #1;
    $display("async reset: count=%0d valid=%b data=%h full=%b ovf=%b itr=%b", count, m_valid, m_data, full, ovf, itr);
    checks++; if (count !== 4'd0 || m_valid !== 1'b0 || m_data !== 16'h0000) begin
      errors++; $display("FAIL async_reset_stream: got count=%0d valid=%b data=%h expected 0 0 0000", count, m_valid, m_data);
    end
    checks++; if (full !== 1'b0 || ovf !== 1'b0 || itr !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags: got full=%b ovf=%b itr=%b expected 0 0 0", full, ovf, itr);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    io_out = 16'h7777;
    out_en = 1'b1;
    step();
    out_en = 1'b0;
    $display("write after reset: data=7777 count=%0d head=%h", count, m_data);
    checks++; if (count !== 4'd1 || m_valid !== 1'b1 || m_data !== 16'h7777) begin
      errors++; $display("FAIL post_reset_write: got count=%0d valid=%b data=%h expected 1 1 7777", count, m_valid, m_data);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_drain: valid got %b expected 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_other_port();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_stream();
    test_itr_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_out_fifo.md
# proc_out_fifo

Output-port buffer placed directly downstream of the processor's I/O output bus. It captures every `out_en` write addressed to its port number into a FIFO and drains the words to an external consumer through a valid/ready stream, so the program never stalls on a slow peripheral. It reports fill level and overflow, and can optionally raise a refill interrupt to the processor's `itr` input.

## Interface
Parameters:
- `NUBITS`, 16: data word width; must match the processor word.
- `NBIOOU`, 2: width of the processor output address.
- `PORT`, 0: output address this block responds to (0 .. 2^NBIOOU-1).
- `FDEPTH`, 8: FIFO depth in words; power of 2, at least 2.
- `ITRLVL`, 2: refill threshold in words (0 .. FDEPTH-1); used only with the interrupt feature.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `io_out`  in  NUBITS  processor output data.
- `addr_out`  in  NBIOOU  processor output address.
- `out_en`  in  1  processor output strobe, one cycle per word.
- `m_data`  out  NUBITS  head-of-FIFO word.
- `m_valid`  out  1  `m_data` holds a valid word.
- `m_ready`  in  1  consumer accepts the word.
- `count`  out  $clog2(FDEPTH)+1  words currently stored.
- `full`  out  1  count == FDEPTH.
- `ovf`  out  1  sticky overflow flag.
- `ovf_clr`  in  1  clears `ovf`.
- `itr`  out  1  refill interrupt pulse, routed to the processor `itr` input.

## Operation
- Write: `wr = out_en && addr_out == PORT`. Strobes addressed to any other port are ignored.
- Read (pop): `rd = m_valid && m_ready`.
- Storage: circular buffer with `$clog2(FDEPTH)`-bit read and write pointers. Both pointers wrap modulo FDEPTH.
- Show-ahead behaviour: `m_data` is the word at the read pointer, presented from a registered output. `m_data` is don't-care while `m_valid` = 0.
- The stream follows AXI-style rules:
  - While `m_valid` = 1 and `m_ready` = 0, `m_data` and `m_valid` hold steady.
  - `m_valid` never depends combinationally on `m_ready`.
- Write while full and not popping: the word is dropped, pointers and `count` are unchanged, and `ovf` is set.
- Write while full and popping in the same cycle: the write is accepted, `count` stays FDEPTH, and `ovf` is not set.
- Simultaneous write and read when `count` = 1: the old head is popped, the new word becomes the head, and `m_valid` stays 1.
- Write into an empty FIFO with `m_ready` = 1: no bypass. The word first appears on `m_data` the following cycle.
- `ovf` is cleared by `ovf_clr`. If `ovf_clr` and an overflowing write happen in the same cycle, set wins and `ovf` = 1.
- Reset (async assert at any time, including mid-stream):
  - Pointers, `count`, `m_valid`, `full`, `ovf` and `itr` all go to 0. `m_data` goes to 0.
  - Buffer contents are not cleared.
  - The first write after reset release is accepted normally.

## Timing
- Write-to-valid latency is 1 clock. A write sampled at edge N gives `m_valid` = 1 after edge N.
- A pop at edge N presents the next word, or `m_valid` = 0 if the FIFO is now empty, after edge N.
- Sustained throughput is 1 word/clock in and 1 word/clock out.
- `count`, `full` and `ovf` are registered and update after the edge on which the event is sampled.
- `itr` is registered, 1 clock wide, and asserted after the edge that caused it.

## Configuration
- Macro: `OUT_FIFO_ITR_EN`.
- Defined:
  - `itr` pulses for exactly one cycle when a pop moves `count` from ITRLVL+1 to ITRLVL.
  - Writes never trigger it.
  - A simultaneous write and pop leaves `count` unchanged and does not trigger it.
- Not defined: `itr` is tied to 0, the threshold logic is not synthesized, and `ITRLVL` is ignored.

## Test plan
- Reset, then write 0x1111, 0x2222, 0x3333 to PORT with `m_ready` = 0 → `count` = 3, `m_valid` = 1, `m_data` = 0x1111. Raise `m_ready` → 0x1111, 0x2222, 0x3333 on consecutive cycles, then `m_valid` = 0 and `count` = 0.
- Write 0xAAAA to PORT+1 → no change: `count` = 0 and `m_valid` = 0.
- FDEPTH = 8: write 9 words 1..9 with `m_ready` = 0 → `full` = 1, `ovf` = 1, and the drain yields 1..8 only. Pulse `ovf_clr` → `ovf` = 0.
- With `full` = 1, write 0x00FF while popping in the same cycle → `ovf` stays 0, `count` stays 8, and 0x00FF is the last word drained.
- Toggle `m_ready` pseudo-randomly while streaming 100 sequential words through wrap-around → output is in order with no loss or duplication, and `m_data` is stable whenever `m_valid` = 1 and `m_ready` = 0.
- With `OUT_FIFO_ITR_EN` and ITRLVL = 2: fill to 5, then drain → a single `itr` pulse on the pop taking `count` 3→2. Assert `rst` mid-drain → all outputs are 0 immediately.
